// File: rtl/fsqrt_unit.sv
// fsqrt_unit: IEEE-754 binary32 square root wrapped around an external integer sqrt core.
// Macro FSQRT_ROUND_EN adds shift-add squaring of the root and round-to-nearest with NX.
module fsqrt_unit #(
    parameter int CORE_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic [23:0] core_in,
    input  logic [47:0] core_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_flags
);

    typedef enum logic [2:0] {IDLE, SETTLE, SQUARE, ROUND, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [23:0] core_in_q, core_in_d;
    logic [23:0] q_q, q_d;
    logic [7:0]  exp_q, exp_d;
    logic [31:0] out_data_q, out_data_d;
    logic [1:0]  out_flags_q, out_flags_d;

    logic        sign_in;
    logic [7:0]  exp_in;
    logic [22:0] frac_in;
    logic        unused_bits;

    assign sign_in = in_data[31];
    assign exp_in  = in_data[30:23];
    assign frac_in = in_data[22:0];

`ifdef FSQRT_ROUND_EN
    logic [47:0] acc_q, acc_d;
    logic [47:0] radicand;
    logic [47:0] sq_plus_q;
    logic        round_up;
    logic [24:0] q_rnd;
    logic [4:0]  bit_idx;

    assign radicand  = {core_in_q, 24'b0};
    assign sq_plus_q = acc_q + {24'b0, q_q};
    // Q*Q + Q < R is equivalent to (Q + 0.5)^2 < R without fractional bits.
    assign round_up  = sq_plus_q < radicand;
    assign q_rnd     = {1'b0, q_q} + {24'b0, round_up};
    assign bit_idx   = 5'd23 - cnt_q;
    assign unused_bits = ^{core_out[23:0], q_rnd[23]};
`else
    assign unused_bits = ^{core_out[23:0], q_q[23]};
`endif

    // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        core_in_d   = core_in_q;
        q_d         = q_q;
        exp_d       = exp_q;
        out_data_d  = out_data_q;
        out_flags_d = out_flags_q;
`ifdef FSQRT_ROUND_EN
        acc_d       = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = DONE;
                    if (exp_in == 8'h00) begin
                        out_data_d  = {sign_in, 31'b0};
                        out_flags_d = 2'b00;
                    end else if (exp_in == 8'hFF && frac_in != 23'b0) begin
                        out_data_d  = 32'h7FC0_0000;
                        out_flags_d = {~frac_in[22], 1'b0};
                    end else if (sign_in) begin
                        out_data_d  = 32'h7FC0_0000;
                        out_flags_d = 2'b10;
                    end else if (exp_in == 8'hFF) begin
                        out_data_d  = 32'h7F80_0000;
                        out_flags_d = 2'b00;
                    end else begin
                        // Odd biased exponent means even unbiased E: halve the significand.
                        core_in_d = exp_in[0] ? {1'b0, 1'b1, frac_in[22:1]} : {1'b1, frac_in};
                        // (exp + 127) >> 1 equals floor((exp - 127) / 2) + 127.
                        exp_d     = 8'(({1'b0, exp_in} + 9'd127) >> 1);
                        cnt_d     = 5'd0;
                        state_d   = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == 5'(CORE_WAIT - 1)) begin
                    q_d   = core_out[47:24];
                    cnt_d = 5'd0;
`ifdef FSQRT_ROUND_EN
                    acc_d   = 48'b0;
                    state_d = SQUARE;
`else
                    state_d = ROUND;
`endif
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
`ifdef FSQRT_ROUND_EN
            SQUARE: begin
                // MSB-first shift-add: after 24 steps acc holds Q*Q.
                acc_d = {acc_q[46:0], 1'b0} + (q_q[bit_idx] ? {24'b0, q_q} : 48'b0);
                if (cnt_q == 5'd23) begin
                    cnt_d   = 5'd0;
                    state_d = ROUND;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
`endif
            ROUND: begin
`ifdef FSQRT_ROUND_EN
                if (q_rnd[24]) begin
                    out_data_d = {1'b0, exp_q + 8'd1, 23'b0};
                end else begin
                    out_data_d = {1'b0, exp_q, q_rnd[22:0]};
                end
                out_flags_d = {1'b0, acc_q != radicand};
`else
                out_data_d  = {1'b0, exp_q, q_q[22:0]};
                out_flags_d = 2'b00;
`endif
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            core_in_q   <= 24'b0;
            q_q         <= 24'b0;
            exp_q       <= 8'b0;
            out_data_q  <= 32'b0;
            out_flags_q <= 2'b0;
`ifdef FSQRT_ROUND_EN
            acc_q       <= 48'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            core_in_q   <= core_in_d;
            q_q         <= q_d;
            exp_q       <= exp_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
`ifdef FSQRT_ROUND_EN
            acc_q       <= acc_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;
    assign core_in   = core_in_q;

endmodule
